alu_pipe: RTL and testbench

//  Parametrised, registered successor of the combinational datapath ALU: W-bit
//  add/sub/logic/move plus carry-chained ADC/SBC, a persistent ZNCV flag register
//  and an optional iterative multiplier. Sits between operand fetch and writeback

---
 rtl/alu_pipe.sv | 249 ++++++++++++++++++++++++
 tb/tb_alu_pipe.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// ============================================================================
// alu_pipe
// ----------------------------------------------------------------------------
// Registered W-bit ALU with a valid/ready handshake on both sides and one
// operation in flight at a time. It supports add/sub/compare, logic ops, move,
// carry-chained ADC/SBC, a persistent {Z,N,C,V} flag register and an optional
// iterative shift-add multiplier.
//
// Build option:
//   ALU_MUL_EN  defined   -> op 9 (MUL) runs W shift-add steps in a MUL state.
//               undefined -> op 9 is handled like any undefined opcode
//                            (result 0, flags kept, latency 1).
//
// Parameters:
//   W      datapath width (>= 4)
//   CNT_W  multiplier step counter width (2**CNT_W must exceed W)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operation presented by the source
//   in_ready   operation can be accepted this cycle
//   op         0 ADD,1 SUB,2 CMP,3 AND,4 ORR,5 EOR,6 MOV,7 ADC,8 SBC,9 MUL
//   set_flags  op updates the flag register (CMP always updates)
//   a, b       operands
//   out_valid  data_out holds a completed result
//   out_ready  consumer takes the result this cycle
//   data_out   registered result
//   flag_out   flag register {Z,N,C,V} on bits [3:0]
// ============================================================================
module alu_pipe #(
    parameter int W     = 32,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   op,
    input  logic         set_flags,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] data_out,
    output logic [3:0]   flag_out
);

    if (W < 4 || (2 ** CNT_W) <= W) begin : g_param_check
        $error("alu_pipe: W must be >= 4 and 2**CNT_W must exceed W");
    end

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_CMP = 4'd2,
        OP_AND = 4'd3,
        OP_ORR = 4'd4,
        OP_EOR = 4'd5,
        OP_MOV = 4'd6,
        OP_ADC = 4'd7,
        OP_SBC = 4'd8,
        OP_MUL = 4'd9
    } op_t;

    // Flag register bit positions.
    localparam int FZ = 3;
    localparam int FN = 2;
    localparam int FC = 1;
    localparam int FV = 0;

    op_t          op_e;
    logic         out_valid_q;
    logic [W-1:0] data_q;
    logic [3:0]   flag_q;
    logic         accept;
    logic         accept_mul;

    // Single shared adder: a + (b or ~b) + carry-in.
    logic [W-1:0] bx;
    logic         cin;
    logic [W:0]   sum_w;
    logic         carry_into_msb;
    logic [3:0]   arith_flags;

    logic [W-1:0] logic_res;
    logic [W-1:0] alu_res;
    logic [3:0]   alu_flags;
    logic         alu_fwr;

    assign op_e = op_t'(op);

`ifdef ALU_MUL_EN
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [W-1:0]     mcand_q;
    logic [W-1:0]     mplier_q;
    logic [W-1:0]     acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mul_sf_q;
    logic             mul_last;
    logic [W-1:0]     mul_acc_next;

    assign in_ready     = !rst && (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept       = in_valid && in_ready;
    assign accept_mul   = accept && (op_e == OP_MUL);
    assign mul_last     = (state_q == S_MUL) && (cnt_q == CNT_W'(W - 1));
    assign mul_acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept_mul) state_d = S_MUL;
            S_MUL:  if (mul_last)   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end
`else
    assign in_ready   = !rst && (!out_valid_q || out_ready);
    assign accept     = in_valid && in_ready;
    assign accept_mul = 1'b0;
`endif

    always_comb begin
        bx  = b;
        cin = 1'b0;
        case (op_e)
            OP_SUB, OP_CMP: begin
                bx  = ~b;
                cin = 1'b1;
            end
            OP_ADC: cin = flag_q[FC];
            OP_SBC: begin
                bx  = ~b;
                cin = flag_q[FC];
            end
            default: ;
        endcase
    end

    assign sum_w          = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, cin};
    // Carry into the MSB is recovered from the MSB sum bit and its inputs.
    assign carry_into_msb = a[W-1] ^ bx[W-1] ^ sum_w[W-1];
    assign arith_flags    = {(sum_w[W-1:0] == '0), sum_w[W-1], sum_w[W],
                             carry_into_msb ^ sum_w[W]};

    always_comb begin
        logic_res = '0;
        alu_res   = '0;
        alu_flags = flag_q;
        alu_fwr   = 1'b0;
        case (op_e)
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
                alu_res   = sum_w[W-1:0];
                alu_flags = arith_flags;
                alu_fwr   = set_flags;
            end
            OP_CMP: begin
                alu_flags = arith_flags;
                alu_fwr   = 1'b1;
            end
            OP_AND, OP_ORR, OP_EOR, OP_MOV: begin
                case (op_e)
                    OP_AND:  logic_res = a & b;
                    OP_ORR:  logic_res = a | b;
                    OP_EOR:  logic_res = a ^ b;
                    default: logic_res = a;
                endcase
                alu_res   = logic_res;
                alu_flags = {(logic_res == '0), logic_res[W-1], flag_q[FC], flag_q[FV]};
                alu_fwr   = set_flags;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            data_q      <= '0;
            flag_q      <= '0;
`ifdef ALU_MUL_EN
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            mul_sf_q    <= 1'b0;
`endif
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end

            // A new result overrides the consume above when both occur on one edge.
            if (accept && !accept_mul) begin
                data_q      <= alu_res;
                out_valid_q <= 1'b1;
                if (alu_fwr) begin
                    flag_q <= alu_flags;
                end
            end

`ifdef ALU_MUL_EN
            if (accept_mul) begin
                mcand_q  <= a;
                mplier_q <= b;
                acc_q    <= '0;
                cnt_q    <= '0;
                mul_sf_q <= set_flags;
            end

            if (state_q == S_MUL) begin
                acc_q    <= mul_acc_next;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + 1'b1;
                // Final step writes its partial sum straight to the output.
                if (mul_last) begin
                    data_q      <= mul_acc_next;
                    out_valid_q <= 1'b1;
                    cnt_q       <= '0;
                    if (mul_sf_q) begin
                        flag_q <= {(mul_acc_next == '0), mul_acc_next[W-1],
                                   flag_q[FC], flag_q[FV]};
                    end
                end
            end
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign data_out  = data_q;
    assign flag_out  = flag_q;

endmodule

// File: tb/tb_alu_pipe.sv
// ============================================================================
// tb_alu_pipe
// ----------------------------------------------------------------------------
// Directed self-checking bench for alu_pipe at W=32. Each task drives one
// scenario and checks outputs sampled 1ns after the rising edge. MUL
// expectations follow the ALU_MUL_EN build option.
// ============================================================================
module tb_alu_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic        set_flags;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_out;
    logic [3:0]  flag_out;

    int checks;
    int errors;

    alu_pipe #(
        .W     (32),
        .CNT_W (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .set_flags (set_flags),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .flag_out  (flag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [3:0] o, input logic sf,
                         input logic [31:0] aa, input logic [31:0] bb);
        in_valid  = 1'b1;
        op        = o;
        set_flags = sf;
        a         = aa;
        b         = bb;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op = 4'd0; set_flags = 1'b0; a = '0; b = '0;
        tick();
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 00000000", data_out); end
        checks++; if (flag_out !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", flag_out); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_add();
        drive(4'd0, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001);
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %b exp 1", out_valid); end
        checks++; if (data_out !== 32'h8000_0000) begin errors++; $display("FAIL add_data got %h exp 80000000", data_out); end
        checks++; if (flag_out !== 4'b0101) begin errors++; $display("FAIL add_flags got %b exp 0101", flag_out); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_consumed got %b exp 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        drive(4'd1, 1'b1, 32'h5, 32'h5);
        tick();
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL sub_data got %h exp 00000000", data_out); end
        checks++; if (flag_out !== 4'b1010) begin errors++; $display("FAIL sub_flags got %b exp 1010", flag_out); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b exp 1", in_ready); end
        drive(4'd7, 1'b1, 32'h1, 32'h1);
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL adc_valid got %b exp 1", out_valid); end
        checks++; if (data_out !== 32'h3) begin errors++; $display("FAIL adc_data got %h exp 00000003", data_out); end
        checks++; if (flag_out !== 4'b0000) begin errors++; $display("FAIL adc_flags got %b exp 0000", flag_out); end
        tick();
    endtask

    task automatic test_cmp_logic();
        drive(4'd2, 1'b0, 32'h3, 32'h7);
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL cmp_valid got %b exp 1", out_valid); end
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL cmp_data got %h exp 00000000", data_out); end
        checks++; if (flag_out !== 4'b0100) begin errors++; $display("FAIL cmp_flags got %b exp 0100", flag_out); end
        drive(4'd3, 1'b1, 32'hF0, 32'h0F);
        tick();
        in_valid = 1'b0;
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL and_data got %h exp 00000000", data_out); end
        checks++; if (flag_out !== 4'b1000) begin errors++; $display("FAIL and_flags got %b exp 1000", flag_out); end
        tick();
    endtask

    task automatic test_mul();
        int  n;
        logic busy_ready;
        drive(4'd9, 1'b1, 32'h0000_FFFF, 32'h0001_0001);
        tick();
        in_valid = 1'b0;
        a = 32'hDEAD_BEEF;
        b = 32'h1234_5678;
`ifdef ALU_MUL_EN
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mul_early_valid got %b exp 0", out_valid); end
        n = 0;
        busy_ready = 1'b0;
        while (out_valid !== 1'b1 && n < 100) begin
            if (in_ready !== 1'b0) busy_ready = 1'b1;
            tick();
            n++;
        end
        checks++; if (n !== 32) begin errors++; $display("FAIL mul_latency got %0d exp 32", n); end
        checks++; if (busy_ready !== 1'b0) begin errors++; $display("FAIL mul_busy_in_ready got %b exp 0", busy_ready); end
        checks++; if (data_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mul_data got %h exp ffffffff", data_out); end
        checks++; if (flag_out !== 4'b0100) begin errors++; $display("FAIL mul_flags got %b exp 0100", flag_out); end
`else
        n = 1;
        busy_ready = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mul_valid got %b exp 1 (n=%0d busy=%b)", out_valid, n, busy_ready); end
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL mul_data got %h exp 00000000", data_out); end
        checks++; if (flag_out !== 4'b1000) begin errors++; $display("FAIL mul_flags got %b exp 1000", flag_out); end
`endif
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(4'd0, 1'b0, 32'h2, 32'h3);
        tick();
        drive(4'd1, 1'b0, 32'h9, 32'h1);
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %b exp 0", i, in_ready); end
            checks++; if (out_valid !== 1'b1 || data_out !== 32'h5) begin
                errors++; $display("FAIL bp_hold[%0d] got v=%b d=%h exp v=1 d=00000005", i, out_valid, data_out);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || data_out !== 32'h8) begin
            errors++; $display("FAIL bp_second got v=%b d=%h exp v=1 d=00000008", out_valid, data_out);
        end
`ifdef ALU_MUL_EN
        checks++; if (flag_out !== 4'b0100) begin errors++; $display("FAIL bp_flags got %b exp 0100", flag_out); end
`else
        checks++; if (flag_out !== 4'b1000) begin errors++; $display("FAIL bp_flags got %b exp 1000", flag_out); end
`endif
        tick();
    endtask

    task automatic test_sbc();
        drive(4'd1, 1'b1, 32'h3, 32'h5);
        tick();
        checks++; if (data_out !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_neg_data got %h exp fffffffe", data_out); end
        checks++; if (flag_out !== 4'b0100) begin errors++; $display("FAIL sub_neg_flags got %b exp 0100", flag_out); end
        drive(4'd8, 1'b1, 32'hA, 32'h3);
        tick();
        in_valid = 1'b0;
        checks++; if (data_out !== 32'h6) begin errors++; $display("FAIL sbc_data got %h exp 00000006", data_out); end
        checks++; if (flag_out !== 4'b0010) begin errors++; $display("FAIL sbc_flags got %b exp 0010", flag_out); end
        tick();
    endtask

    task automatic test_logic_nosf();
        drive(4'd4, 1'b0, 32'hF0, 32'h0F);
        tick();
        checks++; if (data_out !== 32'hFF) begin errors++; $display("FAIL orr_data got %h exp 000000ff", data_out); end
        drive(4'd5, 1'b0, 32'hFF, 32'h0F);
        tick();
        checks++; if (data_out !== 32'hF0) begin errors++; $display("FAIL eor_data got %h exp 000000f0", data_out); end
        drive(4'd6, 1'b0, 32'h8000_ABCD, 32'h1111_1111);
        tick();
        in_valid = 1'b0;
        checks++; if (data_out !== 32'h8000_ABCD) begin errors++; $display("FAIL mov_data got %h exp 8000abcd", data_out); end
        checks++; if (flag_out !== 4'b0010) begin errors++; $display("FAIL nosf_flags got %b exp 0010", flag_out); end
        tick();
    endtask

    task automatic test_undefined();
        drive(4'd0, 1'b0, 32'h1, 32'h1);
        tick();
        drive(4'd12, 1'b1, 32'h5, 32'h5);
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL undef_valid got %b exp 1", out_valid); end
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL undef_data got %h exp 00000000", data_out); end
        checks++; if (flag_out !== 4'b0010) begin errors++; $display("FAIL undef_flags got %b exp 0010", flag_out); end
        tick();
    endtask

    task automatic test_reset_mid_mul();
        drive(4'd9, 1'b1, 32'h0000_FFFF, 32'h0001_0001);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmul_valid got %b exp 0", out_valid); end
        checks++; if (flag_out !== 4'b0000) begin errors++; $display("FAIL rstmul_flags got %b exp 0000", flag_out); end
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL rstmul_data got %h exp 00000000", data_out); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmul_in_ready got %b exp 1", in_ready); end
        drive(4'd0, 1'b0, 32'h1, 32'h1);
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || data_out !== 32'h2) begin
            errors++; $display("FAIL rstmul_add got v=%b d=%h exp v=1 d=00000002", out_valid, data_out);
        end
        for (int i = 0; i < 40; i++) tick();
        checks++; if (out_valid !== 1'b0 || data_out !== 32'h2) begin
            errors++; $display("FAIL rstmul_no_stale got v=%b d=%h exp v=0 d=00000002", out_valid, data_out);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_add();
        test_back_to_back();
        test_cmp_logic();
        test_mul();
        test_backpressure();
        test_sbc();
        test_logic_nosf();
        test_undefined();
        test_reset_mid_mul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
